// File: rtl/ex_pkg.sv
// ex_pkg: op classes, op codes and divider FSM encoding for ex_stage_p.
// Shared by ex_stage_p and ex_div (divider built only with EX_DIV_EN).
package ex_pkg;

  localparam logic [2:0] SEL_LOGIC  = 3'b001;
  localparam logic [2:0] SEL_SHIFT  = 3'b010;
  localparam logic [2:0] SEL_MOVE   = 3'b011;
  localparam logic [2:0] SEL_MULDIV = 3'b100;

  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_ANDI  = 8'h0C;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_ORI   = 8'h0D;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_XORI  = 8'h0E;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_LUI   = 8'h0F;
  localparam logic [7:0] OP_SLL   = 8'h00;
  localparam logic [7:0] OP_SLLV  = 8'h04;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRLV  = 8'h06;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_SRAV  = 8'h07;
  localparam logic [7:0] OP_MOVZ  = 8'h0A;
  localparam logic [7:0] OP_MOVN  = 8'h0B;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_BUSY = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

endpackage

// File: rtl/ex_div.sv
// ex_div: iterative restoring divider, one quotient bit per cycle.
// Zero divisor skips BUSY: quotient all ones, remainder = dividend.
module ex_div
  import ex_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo, rem, dvs;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             neg_q, neg_r, a_neg, b_neg;
  logic [WIDTH:0]   shifted, diff;

  assign a_neg = signed_op & dividend[WIDTH-1];
  assign b_neg = signed_op & divisor[WIDTH-1];
  assign abs_a = a_neg ? -dividend : dividend;
  assign abs_b = b_neg ? -divisor : divisor;

  // partial remainder stays below dvs, so WIDTH+1 bits cover the shift
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs};

  assign busy      = state == DIV_BUSY;
  assign done      = state == DIV_DONE;
  assign quotient  = neg_q ? -quo : quo;
  assign remainder = neg_r ? -rem : rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (flush) begin
      state <= DIV_IDLE;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (start) begin
            cnt <= '0;
            dvs <= abs_b;
            if (divisor == '0) begin
              quo   <= '1;
              rem   <= dividend;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= DIV_DONE;
            end else begin
              quo   <= abs_a;
              rem   <= '0;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
              state <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          if (diff[WIDTH]) begin
            rem <= shifted[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end else begin
            rem <= diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= DIV_DONE;
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_p.sv
// ex_stage_p: execute stage (logic/shift/move/HI-LO/mul, iterative div).
// Define EX_DIV_EN to build the divider; otherwise DIV/DIVU are no-ops.
module ex_stage_p
  import ex_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         alusel,
  input  logic [7:0]         aluop,
  input  logic [WIDTH-1:0]   reg1_data,
  input  logic [WIDTH-1:0]   reg2_data,
  input  logic               id_we,
  input  logic [RADDR_W-1:0] id_waddr,
  input  logic [WIDTH-1:0]   hilo_hi,
  input  logic [WIDTH-1:0]   hilo_lo,
  input  logic               mem_whilo,
  input  logic [WIDTH-1:0]   mem_hi,
  input  logic [WIDTH-1:0]   mem_lo,
  input  logic               wb_whilo,
  input  logic [WIDTH-1:0]   wb_hi,
  input  logic [WIDTH-1:0]   wb_lo,
  input  logic               flush,
  output logic               stall_req,
  output logic               ex_we,
  output logic [RADDR_W-1:0] ex_waddr,
  output logic [WIDTH-1:0]   ex_wdata,
  output logic               ex_whilo,
  output logic [WIDTH-1:0]   ex_hi,
  output logic [WIDTH-1:0]   ex_lo
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0]      sh;
  logic [WIDTH-1:0]   fwd_hi, fwd_lo;
  logic [WIDTH-1:0]   wdata_n, hi_n, lo_n;
  logic [2*WIDTH-1:0] op1_x, op2_x, prod;
  logic               we_n, whilo_n, is_div, div_done;
  logic [WIDTH-1:0]   div_q, div_r;
  logic               sel_logic, sel_shift, sel_move, sel_md;

  assign sel_logic = alusel == SEL_LOGIC;
  assign sel_shift = alusel == SEL_SHIFT;
  assign sel_move  = alusel == SEL_MOVE;
  assign sel_md    = alusel == SEL_MULDIV;

  assign sh     = reg1_data[SW-1:0];
  assign is_div = sel_md & (aluop == OP_DIV || aluop == OP_DIVU);

  assign fwd_hi = mem_whilo ? mem_hi : wb_whilo ? wb_hi : hilo_hi;
  assign fwd_lo = mem_whilo ? mem_lo : wb_whilo ? wb_lo : hilo_lo;

  // extend to 2*WIDTH so one multiplier serves MULT and MULTU
  assign op1_x = (aluop == OP_MULT) ?
    {{WIDTH{reg1_data[WIDTH-1]}}, reg1_data} : {{WIDTH{1'b0}}, reg1_data};
  assign op2_x = (aluop == OP_MULT) ?
    {{WIDTH{reg2_data[WIDTH-1]}}, reg2_data} : {{WIDTH{1'b0}}, reg2_data};
  assign prod = op1_x * op2_x;

`ifdef EX_DIV_EN
  logic div_busy;

  ex_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (is_div),
    .signed_op (aluop == OP_DIV),
    .dividend  (reg1_data),
    .divisor   (reg2_data),
    .flush     (flush),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  assign stall_req = ~reset & ~flush & (div_busy | (is_div & ~div_done));
`else
  assign stall_req = 1'b0;
  assign div_done  = 1'b0;
  assign div_q     = '0;
  assign div_r     = '0;
`endif

  always_comb begin
    wdata_n = '0;
    we_n    = id_we;
    whilo_n = 1'b0;
    hi_n    = '0;
    lo_n    = '0;
    unique case (1'b1)
      sel_logic: begin
        case (aluop)
          OP_AND, OP_ANDI: wdata_n = reg1_data & reg2_data;
          OP_OR, OP_ORI:   wdata_n = reg1_data | reg2_data;
          OP_XOR, OP_XORI: wdata_n = reg1_data ^ reg2_data;
          OP_NOR:          wdata_n = ~(reg1_data | reg2_data);
          OP_LUI:          wdata_n = reg2_data << 16;
          default:         wdata_n = '0;
        endcase
      end
      sel_shift: begin
        case (aluop)
          OP_SLL, OP_SLLV: wdata_n = reg2_data << sh;
          OP_SRL, OP_SRLV: wdata_n = reg2_data >> sh;
          OP_SRA, OP_SRAV: wdata_n = $signed(reg2_data) >>> sh;
          default:         wdata_n = '0;
        endcase
      end
      sel_move: begin
        case (aluop)
          OP_MOVZ: begin
            wdata_n = reg1_data;
            we_n    = id_we & (reg2_data == '0);
          end
          OP_MOVN: begin
            wdata_n = reg1_data;
            we_n    = id_we & (reg2_data != '0);
          end
          OP_MFHI: wdata_n = fwd_hi;
          OP_MFLO: wdata_n = fwd_lo;
          OP_MTHI: begin
            whilo_n = 1'b1;
            hi_n    = reg1_data;
            lo_n    = fwd_lo;
          end
          OP_MTLO: begin
            whilo_n = 1'b1;
            hi_n    = fwd_hi;
            lo_n    = reg1_data;
          end
          default: wdata_n = '0;
        endcase
      end
      sel_md: begin
        case (aluop)
          OP_MULT, OP_MULTU: begin
            whilo_n      = 1'b1;
            {hi_n, lo_n} = prod;
          end
          OP_DIV, OP_DIVU: we_n = 1'b0;
          default: wdata_n = '0;
        endcase
      end
      default: wdata_n = '0;
    endcase
    if (div_done) begin
      whilo_n = 1'b1;
      we_n    = 1'b0;
      hi_n    = div_r;
      lo_n    = div_q;
    end
    if (stall_req | flush) begin
      we_n    = 1'b0;
      whilo_n = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_we    <= 1'b0;
      ex_waddr <= '0;
      ex_wdata <= '0;
      ex_whilo <= 1'b0;
      ex_hi    <= '0;
      ex_lo    <= '0;
    end else begin
      ex_we    <= we_n;
      ex_waddr <= id_waddr;
      ex_wdata <= wdata_n;
      ex_whilo <= whilo_n;
      ex_hi    <= hi_n;
      ex_lo    <= lo_n;
    end
  end

endmodule

// File: tb/tb_ex_stage_p.sv
// tb_ex_stage_p: directed + randomized checks of ex_stage_p against a model.
// Divider scenarios run when EX_DIV_EN is defined, else DIV must be a no-op.
module tb_ex_stage_p;

  logic        clk;
  logic        reset;
  logic [2:0]  alusel;
  logic [7:0]  aluop;
  logic [31:0] reg1_data, reg2_data;
  logic        id_we;
  logic [4:0]  id_waddr;
  logic [31:0] hilo_hi, hilo_lo;
  logic        mem_whilo, wb_whilo;
  logic [31:0] mem_hi, mem_lo, wb_hi, wb_lo;
  logic        flush;
  logic        stall_req;
  logic        ex_we, ex_whilo;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata, ex_hi, ex_lo;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic [7:0] ops [0:21] = '{
    8'h24, 8'h0C, 8'h25, 8'h0D, 8'h26, 8'h0E, 8'h27, 8'h0F,
    8'h00, 8'h04, 8'h02, 8'h06, 8'h03, 8'h07, 8'h0A, 8'h0B,
    8'h10, 8'h11, 8'h12, 8'h13, 8'h18, 8'h19};

  ex_stage_p #(.WIDTH(32), .RADDR_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .alusel    (alusel),
    .aluop     (aluop),
    .reg1_data (reg1_data),
    .reg2_data (reg2_data),
    .id_we     (id_we),
    .id_waddr  (id_waddr),
    .hilo_hi   (hilo_hi),
    .hilo_lo   (hilo_lo),
    .mem_whilo (mem_whilo),
    .mem_hi    (mem_hi),
    .mem_lo    (mem_lo),
    .wb_whilo  (wb_whilo),
    .wb_hi     (wb_hi),
    .wb_lo     (wb_lo),
    .flush     (flush),
    .stall_req (stall_req),
    .ex_we     (ex_we),
    .ex_waddr  (ex_waddr),
    .ex_wdata  (ex_wdata),
    .ex_whilo  (ex_whilo),
    .ex_hi     (ex_hi),
    .ex_lo     (ex_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    alusel = 3'd0;
    aluop  = 8'd0;
    id_we  = 1'b0;
    flush  = 1'b0;
  endtask

  // architectural meaning of one single-cycle op
  function automatic exp_t model();
    exp_t        e;
    logic [31:0] fhi, flo;
    int unsigned sh;
    longint      ps;
    longint unsigned pu;
    e = '0;
    e.we = id_we;
    fhi = mem_whilo ? mem_hi : (wb_whilo ? wb_hi : hilo_hi);
    flo = mem_whilo ? mem_lo : (wb_whilo ? wb_lo : hilo_lo);
    sh = reg1_data % 32;
    case (alusel)
      3'd1: case (aluop)
        8'h24, 8'h0C: e.wdata = reg1_data & reg2_data;
        8'h25, 8'h0D: e.wdata = reg1_data | reg2_data;
        8'h26, 8'h0E: e.wdata = reg1_data ^ reg2_data;
        8'h27:        e.wdata = ~(reg1_data | reg2_data);
        8'h0F:        e.wdata = {reg2_data[15:0], 16'h0};
        default:      e.wdata = 32'h0;
      endcase
      3'd2: case (aluop)
        8'h00, 8'h04: e.wdata = reg2_data << sh;
        8'h02, 8'h06: e.wdata = reg2_data >> sh;
        8'h03, 8'h07: e.wdata = reg2_data[31] ? ~((~reg2_data) >> sh)
                                              : reg2_data >> sh;
        default:      e.wdata = 32'h0;
      endcase
      3'd3: case (aluop)
        8'h0A: begin e.we = id_we && reg2_data == 0; e.wdata = reg1_data; end
        8'h0B: begin e.we = id_we && reg2_data != 0; e.wdata = reg1_data; end
        8'h10: e.wdata = fhi;
        8'h12: e.wdata = flo;
        8'h11: begin e.whilo = 1'b1; e.hi = reg1_data; e.lo = flo; end
        8'h13: begin e.whilo = 1'b1; e.hi = fhi; e.lo = reg1_data; end
        default: e.wdata = 32'h0;
      endcase
      3'd4: case (aluop)
        8'h18: begin
          ps = longint'($signed(reg1_data)) * longint'($signed(reg2_data));
          {e.hi, e.lo} = ps;
          e.whilo = 1'b1;
        end
        8'h19: begin
          pu = 64'(reg1_data) * 64'(reg2_data);
          {e.hi, e.lo} = pu;
          e.whilo = 1'b1;
        end
        8'h1A, 8'h1B: e.we = 1'b0;
        default: e.wdata = 32'h0;
      endcase
      default: e.wdata = 32'h0;
    endcase
    return e;
  endfunction

  task automatic check_op(input string tag);
    exp_t e;
    e = model();
    tick();
    check({tag, ".we"}, 64'(ex_we), 64'(e.we));
    check({tag, ".wdata"}, 64'(ex_wdata), 64'(e.wdata));
    check({tag, ".whilo"}, 64'(ex_whilo), 64'(e.whilo));
    if (e.whilo) check({tag, ".hilo"}, {ex_hi, ex_lo}, {e.hi, e.lo});
  endtask

`ifdef EX_DIV_EN
  task automatic run_div(input string tag, input logic sgn,
                         input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    longint      sa, sb;
    int          n, exp_n;
    logic        bub;
    if (b == 0) begin
      eq = 32'hFFFF_FFFF; er = a; exp_n = 1;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      eq = 32'(sa / sb); er = 32'(sa % sb); exp_n = 33;
    end else begin
      eq = a / b; er = a % b; exp_n = 33;
    end
    alusel = 3'd4; aluop = sgn ? 8'h1A : 8'h1B;
    reg1_data = a; reg2_data = b; id_we = 1'b1; flush = 1'b0;
    #1;
    n = 0; bub = 1'b1;
    while (stall_req && n < 100) begin
      n++;
      tick();
      if (ex_we || ex_whilo) bub = 1'b0;
    end
    check({tag, ".stall_cycles"}, 64'(n), 64'(exp_n));
    check({tag, ".bubble"}, 64'(bub), 64'd1);
    tick();
    check({tag, ".whilo"}, 64'(ex_whilo), 64'd1);
    check({tag, ".we"}, 64'(ex_we), 64'd0);
    check({tag, ".hilo"}, {ex_hi, ex_lo}, {er, eq});
  endtask
`endif

  initial begin
    int   idx;
    logic quiet;
    reset = 1'b1;
    set_nop();
    reg1_data = 0; reg2_data = 0; id_waddr = 0;
    hilo_hi = 0; hilo_lo = 0; mem_whilo = 0; mem_hi = 0; mem_lo = 0;
    wb_whilo = 0; wb_hi = 0; wb_lo = 0;
    #3;
    check("reset.outs", {26'd0, ex_we, ex_waddr, ex_whilo, ex_wdata},
          64'd0);
    check("reset.hilo", {ex_hi, ex_lo}, 64'd0);
    check("reset.stall", 64'(stall_req), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    alusel = 3'd2; aluop = 8'h03; reg1_data = 31; reg2_data = 32'h8000_0000;
    id_we = 1'b1; id_waddr = 5'd3;
    tick();
    check("sra31", 64'(ex_wdata), 64'h0000_0000_FFFF_FFFF);
    check("sra31.waddr", 64'(ex_waddr), 64'd3);
    aluop = 8'h02;
    tick();
    check("srl31", 64'(ex_wdata), 64'd1);

    alusel = 3'd3; aluop = 8'h0B; reg1_data = 32'h5555_1234; reg2_data = 0;
    tick();
    check("movn.zero.we", 64'(ex_we), 64'd0);
    aluop = 8'h0A;
    tick();
    check("movz.zero.we", 64'(ex_we), 64'd1);
    check("movz.zero.wdata", 64'(ex_wdata), 64'h5555_1234);

    aluop = 8'h10; mem_whilo = 1; mem_hi = 32'hAAAA_0000;
    wb_whilo = 1; wb_hi = 32'h1234; hilo_hi = 32'h0BAD_0BAD;
    tick();
    check("mfhi.mem", 64'(ex_wdata), 64'hAAAA_0000);
    mem_whilo = 0;
    tick();
    check("mfhi.wb", 64'(ex_wdata), 64'h1234);
    wb_whilo = 0;
    tick();
    check("mfhi.arch", 64'(ex_wdata), 64'h0BAD_0BAD);

    alusel = 3'd4; aluop = 8'h18; reg1_data = 32'hFFFF_FFFF; reg2_data = 2;
    tick();
    check("mult.hilo", {ex_hi, ex_lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    check("mult.whilo", 64'(ex_whilo), 64'd1);
    set_nop();
    tick();
    check("mult.whilo_once", 64'(ex_whilo), 64'd0);

    for (int i = 0; i < 150; i++) begin
      alusel = 3'($urandom_range(0, 7));
      idx = $urandom_range(0, 25);
      aluop = (idx < 22) ? ops[idx] : 8'($urandom);
      if (alusel == 3'd4 && (aluop == 8'h1A || aluop == 8'h1B)) aluop = 8'h19;
      reg1_data = $urandom;
      reg2_data = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      id_we = 1'($urandom); id_waddr = 5'($urandom);
      hilo_hi = $urandom; hilo_lo = $urandom;
      mem_whilo = 1'($urandom); mem_hi = $urandom; mem_lo = $urandom;
      wb_whilo = 1'($urandom); wb_hi = $urandom; wb_lo = $urandom;
      #1;
      check("rand.stall", 64'(stall_req), 64'd0);
      check_op("rand");
      check("rand.waddr", 64'(ex_waddr), 64'(id_waddr));
    end

`ifdef EX_DIV_EN
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_div("divu_7_0", 1'b0, 32'd7, 32'd0);
    run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++)
      run_div("div_rand", 1'($urandom), $urandom,
              (i == 2) ? 32'h0 : 32'($urandom_range(1, 32'h7FFF_FFFF)));
    set_nop();
    tick();
    check("div.whilo_once", 64'(ex_whilo), 64'd0);

    alusel = 3'd4; aluop = 8'h1A; reg1_data = 100; reg2_data = 3; id_we = 1;
    #1;
    check("flush.stall_start", 64'(stall_req), 64'd1);
    repeat (10) tick();
    flush = 1'b1;
    #1;
    check("flush.stall_drop", 64'(stall_req), 64'd0);
    tick();
    set_nop();
    #1;
    check("flush.stall_next", 64'(stall_req), 64'd0);
    check("flush.we", 64'(ex_we), 64'd0);
    quiet = 1'b1;
    repeat (40) begin
      tick();
      if (ex_whilo || stall_req) quiet = 1'b0;
    end
    check("flush.no_hilo", 64'(quiet), 64'd1);
`else
    alusel = 3'd4; aluop = 8'h1A; reg1_data = 100; reg2_data = 3; id_we = 1;
    #1;
    check("nodiv.stall", 64'(stall_req), 64'd0);
    tick();
    check("nodiv.outs", {31'd0, ex_we, ex_whilo, ex_wdata}, 64'd0);
`endif

    alusel = 3'd4; aluop = 8'h1B; reg1_data = 50; reg2_data = 7;
    id_we = 1'b1; id_waddr = 5'd9;
    repeat (5) tick();
    check("rst_busy.pre_waddr", 64'(ex_waddr), 64'd9);
    #2 reset = 1'b1;
    #1;
    check("rst_busy.outs", {26'd0, ex_we, ex_waddr, ex_whilo, ex_wdata},
          64'd0);
    check("rst_busy.hilo", {ex_hi, ex_lo}, 64'd0);
    check("rst_busy.stall", 64'(stall_req), 64'd0);
    set_nop();
    @(negedge clk);
    reset = 1'b0;
    quiet = 1'b1;
    repeat (40) begin
      tick();
      if (ex_whilo || stall_req) quiet = 1'b0;
    end
    check("rst_busy.aborted", 64'(quiet), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
